// File: rtl/pkg_tpu.sv
// Shared TPU datapath types.
package pkg_tpu;

  typedef logic [15:0] address_t;
  typedef logic [31:0] instr_t;

endpackage

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues instruction-memory reads under a credit scheme,
// buffers returned instructions with their PCs and presents them in order to decode.
module ifetch_queue
  import pkg_tpu::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     I_IFetch,
  input  address_t I_Address,
  input  logic     I_Flush,
  output logic     O_IMem_Re,
  output address_t O_IMem_Addr,
  input  instr_t   I_IMem_Data,
  output logic     O_Valid,
  output instr_t   O_Instr,
  output address_t O_PC,
  input  logic     I_Ready,
  output logic     O_StallReq
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, tail_q;
  logic            inflight_q;
  address_t        inflight_pc_q;
  address_t        addr_q;
  instr_t          instr_mem [DEPTH];
  address_t        pc_mem    [DEPTH];

  logic            has_credit;
  logic            issue;
  logic            push;
  logic            pop;

  // Issue/push/pop decode and combinational outputs.
  always_comb begin
    // Credit is computed from registered state only, so a same-cycle pop never frees a slot.
    has_credit  = (count_q + CW'(inflight_q)) < CW'(DEPTH);
    // Gating with reset keeps the request-side outputs quiet while reset is held.
    issue       = reset & I_IFetch & ~I_Flush & has_credit & (state_q != StFlush);
    push        = inflight_q & ~I_Flush;
    O_Valid     = (count_q != '0) & (state_q != StFlush);
    pop         = O_Valid & I_Ready;
    O_IMem_Re   = issue;
    O_IMem_Addr = issue ? I_Address : addr_q;
    O_StallReq  = reset & I_IFetch & ~issue & ~I_Flush;
    O_Instr     = instr_mem[head_q];
    O_PC        = pc_mem[head_q];
  end

  // Next-state logic for the control FSM and the occupancy counter.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (I_Flush) begin
          state_d = StFlush;
        end else if (I_IFetch) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (I_Flush) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        state_d = I_Flush ? StFlush : StRun;
      end
      default: state_d = StIdle;
    endcase

    if (I_Flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state, pointers and the outstanding-read tracker.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      addr_q        <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (issue) begin
        inflight_pc_q <= I_Address;
        addr_q        <= I_Address;
      end
      if (I_Flush) begin
        head_q     <= '0;
        tail_q     <= '0;
        inflight_q <= 1'b0;
      end else begin
        inflight_q <= issue;
        if (push) begin
          tail_q <= tail_q + PW'(1);
        end
        if (pop) begin
          head_q <= head_q + PW'(1);
        end
      end
    end
  end

  // Entry storage; cleared on reset so the head outputs read zero afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (push) begin
      instr_mem[tail_q] <= I_IMem_Data;
      pc_mem[tail_q]    <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed testbench for ifetch_queue.
module tb_ifetch_queue;
  import pkg_tpu::*;

  logic     clock;
  logic     reset;
  logic     I_IFetch;
  address_t I_Address;
  logic     I_Flush;
  logic     O_IMem_Re;
  address_t O_IMem_Addr;
  instr_t   I_IMem_Data;
  logic     O_Valid;
  instr_t   O_Instr;
  address_t O_PC;
  logic     I_Ready;
  logic     O_StallReq;

  int tests_run;
  int tests_failed;

  ifetch_queue #(.DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .I_IFetch   (I_IFetch),
    .I_Address  (I_Address),
    .I_Flush    (I_Flush),
    .O_IMem_Re  (O_IMem_Re),
    .O_IMem_Addr(O_IMem_Addr),
    .I_IMem_Data(I_IMem_Data),
    .O_Valid    (O_Valid),
    .O_Instr    (O_Instr),
    .O_PC       (O_PC),
    .I_Ready    (I_Ready),
    .O_StallReq (O_StallReq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic instr_t instr_of(input address_t a);
    return {16'hC0DE, a};
  endfunction

  // Instruction memory: returns data one cycle after a read enable.
  always @(posedge clock) begin
    I_IMem_Data <= O_IMem_Re ? instr_of(O_IMem_Addr) : 32'hDEAD_BEEF;
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; I_IFetch = 1'b1; I_Address = 16'h0055; I_Flush = 1'b0; I_Ready = 1'b1;
    #2;
    tests_run++; if (O_IMem_Re !== 1'b0) begin tests_failed++; $display("FAIL reset_re got %b want 0", O_IMem_Re); end
    tests_run++; if (O_StallReq !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %b want 0", O_StallReq); end
    tests_run++; if (O_Valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", O_Valid); end
    tests_run++; if (O_IMem_Addr !== 16'h0) begin tests_failed++; $display("FAIL reset_addr got %h want 0", O_IMem_Addr); end
    tests_run++; if (O_PC !== 16'h0) begin tests_failed++; $display("FAIL reset_pc got %h want 0", O_PC); end
    tests_run++; if (O_Instr !== 32'h0) begin tests_failed++; $display("FAIL reset_instr got %h want 0", O_Instr); end
    next_cycle();
    I_IFetch = 1'b0; I_Ready = 1'b0;
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_streaming();
    for (int c = 1; c <= 7; c++) begin
      I_IFetch = (c <= 4); I_Address = 16'(16'h000F + c); I_Ready = 1'b1; I_Flush = 1'b0;
      #1;
      tests_run++; if (O_IMem_Re !== (c <= 4)) begin tests_failed++; $display("FAIL stream_re c%0d got %b want %b", c, O_IMem_Re, (c <= 4)); end
      if (c <= 4) begin
        tests_run++; if (O_IMem_Addr !== 16'(16'h000F + c)) begin tests_failed++; $display("FAIL stream_addr c%0d got %h", c, O_IMem_Addr); end
      end
      tests_run++; if (O_Valid !== (c >= 3 && c <= 6)) begin tests_failed++; $display("FAIL stream_valid c%0d got %b", c, O_Valid); end
      if (c >= 3 && c <= 6) begin
        tests_run++; if (O_PC !== 16'(16'h0010 + c - 3)) begin tests_failed++; $display("FAIL stream_pc c%0d got %h want %h", c, O_PC, 16'(16'h0010 + c - 3)); end
        tests_run++; if (O_Instr !== instr_of(16'(16'h0010 + c - 3))) begin tests_failed++; $display("FAIL stream_instr c%0d got %h", c, O_Instr); end
      end
      next_cycle();
    end
    I_IFetch = 1'b0; I_Ready = 1'b0;
  endtask

  task automatic test_fill();
    // Cycles 1-6: fetch held, decode stalled.
    for (int c = 1; c <= 6; c++) begin
      I_IFetch = 1'b1; I_Ready = 1'b0; I_Flush = 1'b0;
      I_Address = (c <= 4) ? 16'(16'h0030 + c - 1) : 16'h0034;
      #1;
      tests_run++; if (O_IMem_Re !== (c <= 4)) begin tests_failed++; $display("FAIL fill_re c%0d got %b want %b", c, O_IMem_Re, (c <= 4)); end
      tests_run++; if (O_StallReq !== (c >= 5)) begin tests_failed++; $display("FAIL fill_stall c%0d got %b want %b", c, O_StallReq, (c >= 5)); end
      next_cycle();
    end
    // Full queue with a simultaneous pop: no issue this cycle.
    I_IFetch = 1'b1; I_Address = 16'h0034; I_Ready = 1'b1;
    #1;
    tests_run++; if (O_IMem_Re !== 1'b0) begin tests_failed++; $display("FAIL fullpop_re got %b want 0", O_IMem_Re); end
    tests_run++; if (O_StallReq !== 1'b1) begin tests_failed++; $display("FAIL fullpop_stall got %b want 1", O_StallReq); end
    tests_run++; if (O_PC !== 16'h0030) begin tests_failed++; $display("FAIL fullpop_pc got %h want 0030", O_PC); end
    next_cycle();
    // The freed slot releases exactly one issue.
    I_Ready = 1'b0;
    #1;
    tests_run++; if (O_IMem_Re !== 1'b1) begin tests_failed++; $display("FAIL release_re got %b want 1", O_IMem_Re); end
    tests_run++; if (O_IMem_Addr !== 16'h0034) begin tests_failed++; $display("FAIL release_addr got %h want 0034", O_IMem_Addr); end
    tests_run++; if (O_PC !== 16'h0031) begin tests_failed++; $display("FAIL release_pc got %h want 0031", O_PC); end
    next_cycle();
    I_Address = 16'h0035;
    #1;
    tests_run++; if (O_StallReq !== 1'b1) begin tests_failed++; $display("FAIL release_once got %b want 1", O_StallReq); end
    next_cycle();
    // Drain.
    I_IFetch = 1'b0; I_Ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests_run++; if (O_Valid !== (k < 4)) begin tests_failed++; $display("FAIL drain_valid k%0d got %b", k, O_Valid); end
      if (k < 4) begin
        tests_run++; if (O_PC !== 16'(16'h0031 + k)) begin tests_failed++; $display("FAIL drain_pc k%0d got %h want %h", k, O_PC, 16'(16'h0031 + k)); end
      end
      next_cycle();
    end
    I_Ready = 1'b0;
  endtask

  task automatic test_flush();
    I_IFetch = 1'b1; I_Address = 16'h0020; I_Ready = 1'b1; I_Flush = 1'b0;
    #1;
    tests_run++; if (O_IMem_Re !== 1'b1) begin tests_failed++; $display("FAIL flush_issue got %b want 1", O_IMem_Re); end
    next_cycle();
    I_Flush = 1'b1; I_Address = 16'h0024;
    #1;
    tests_run++; if (O_IMem_Re !== 1'b0) begin tests_failed++; $display("FAIL flush_re got %b want 0", O_IMem_Re); end
    tests_run++; if (O_StallReq !== 1'b0) begin tests_failed++; $display("FAIL flush_stall got %b want 0", O_StallReq); end
    tests_run++; if (O_Valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid0 got %b want 0", O_Valid); end
    next_cycle();
    I_Flush = 1'b0;
    #1;
    tests_run++; if (O_IMem_Re !== 1'b0) begin tests_failed++; $display("FAIL flushst_re got %b want 0", O_IMem_Re); end
    tests_run++; if (O_StallReq !== 1'b1) begin tests_failed++; $display("FAIL flushst_stall got %b want 1", O_StallReq); end
    tests_run++; if (O_Valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid1 got %b want 0", O_Valid); end
    next_cycle();
    I_Address = 16'h0040;
    #1;
    tests_run++; if (O_IMem_Re !== 1'b1) begin tests_failed++; $display("FAIL refetch_re got %b want 1", O_IMem_Re); end
    next_cycle();
    I_IFetch = 1'b0;
    #1;
    tests_run++; if (O_Valid !== 1'b0) begin tests_failed++; $display("FAIL refetch_early got %b want 0", O_Valid); end
    next_cycle();
    #1;
    tests_run++; if (O_Valid !== 1'b1) begin tests_failed++; $display("FAIL refetch_valid got %b want 1", O_Valid); end
    tests_run++; if (O_PC !== 16'h0040) begin tests_failed++; $display("FAIL refetch_pc got %h want 0040", O_PC); end
    next_cycle();
    #1;
    tests_run++; if (O_Valid !== 1'b0) begin tests_failed++; $display("FAIL flush_empty got %b want 0", O_Valid); end
    I_Ready = 1'b0;
  endtask

  task automatic test_wrap();
    for (int c = 1; c <= 12; c++) begin
      I_IFetch = (c <= 10); I_Address = 16'(16'h0050 + c - 1); I_Ready = 1'b1; I_Flush = 1'b0;
      #1;
      if (c <= 10) begin
        tests_run++; if (O_StallReq !== 1'b0) begin tests_failed++; $display("FAIL wrap_stall c%0d got %b want 0", c, O_StallReq); end
      end
      tests_run++; if (O_Valid !== (c >= 3)) begin tests_failed++; $display("FAIL wrap_valid c%0d got %b", c, O_Valid); end
      if (c >= 3) begin
        tests_run++; if (O_PC !== 16'(16'h0050 + c - 3)) begin tests_failed++; $display("FAIL wrap_pc c%0d got %h want %h", c, O_PC, 16'(16'h0050 + c - 3)); end
      end
      next_cycle();
    end
    I_IFetch = 1'b0;
    #1;
    tests_run++; if (O_Valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_dup got %b want 0", O_Valid); end
    I_Ready = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int c = 1; c <= 4; c++) begin
      I_IFetch = 1'b1; I_Address = 16'(16'h0060 + c - 1); I_Ready = 1'b0; I_Flush = 1'b0;
      next_cycle();
    end
    // Three entries queued plus 0x63 outstanding.
    I_IFetch = 1'b0;
    #1;
    tests_run++; if (O_Valid !== 1'b1) begin tests_failed++; $display("FAIL prereset_valid got %b want 1", O_Valid); end
    tests_run++; if (O_PC !== 16'h0060) begin tests_failed++; $display("FAIL prereset_pc got %h want 0060", O_PC); end
    #1 reset = 1'b0;
    #1;
    tests_run++; if (O_Valid !== 1'b0) begin tests_failed++; $display("FAIL areset_valid got %b want 0", O_Valid); end
    tests_run++; if (O_PC !== 16'h0) begin tests_failed++; $display("FAIL areset_pc got %h want 0", O_PC); end
    #1 reset = 1'b1;
    next_cycle();
    #1;
    tests_run++; if (O_Valid !== 1'b0) begin tests_failed++; $display("FAIL stale_data got %b want 0", O_Valid); end
    I_IFetch = 1'b1; I_Address = 16'h0000;
    #1;
    tests_run++; if (O_IMem_Re !== 1'b1) begin tests_failed++; $display("FAIL postreset_re got %b want 1", O_IMem_Re); end
    next_cycle();
    I_IFetch = 1'b0;
    next_cycle();
    #1;
    tests_run++; if (O_Valid !== 1'b1) begin tests_failed++; $display("FAIL postreset_valid got %b want 1", O_Valid); end
    tests_run++; if (O_PC !== 16'h0000) begin tests_failed++; $display("FAIL postreset_pc got %h want 0000", O_PC); end
    tests_run++; if (O_Instr !== instr_of(16'h0000)) begin tests_failed++; $display("FAIL postreset_instr got %h", O_Instr); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_streaming();
    test_fill();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, 4, number of instruction-queue entries; power of two, minimum 2.
REQ-002 Types address_t and instr_t SHALL be taken from pkg_tpu.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 I_IFetch  input  1  fetch request from the program-address unit.
REQ-006 I_Address  input  address_t  program counter to fetch, valid with I_IFetch.
REQ-007 I_Flush  input  1  redirect (taken branch or jump); discard all fetched and in-flight instructions.
REQ-008 O_IMem_Re  output  1  instruction-memory read enable.
REQ-009 O_IMem_Addr  output  address_t  instruction-memory read address.
REQ-010 I_IMem_Data  input  instr_t  read data, valid exactly one cycle after O_IMem_Re.
REQ-011 O_Valid  output  1  head entry valid toward decode.
REQ-012 O_Instr  output  instr_t  head instruction.
REQ-013 O_PC  output  address_t  address of the head instruction.
REQ-014 I_Ready  input  1  decode accepts the head entry this cycle.
REQ-015 O_StallReq  output  1  fetch request cannot be accepted this cycle.

Function
REQ-016 Credit = DEPTH - Count - InFlight, where Count is the number of queued entries and InFlight is 1 when a read is outstanding; a pop in the same cycle SHALL NOT add credit.
REQ-017 The FSM SHALL have states IDLE (after reset, no request seen), RUN and FLUSH.
REQ-018 IDLE->RUN on the first I_IFetch without I_Flush; any state->FLUSH on I_Flush; FLUSH->RUN after exactly one cycle; RUN never returns to IDLE.
REQ-019 Issue condition: I_IFetch & ~I_Flush & (Credit>0) & state!=FLUSH; when met, O_IMem_Re=1 and O_IMem_Addr=I_Address combinationally, and I_Address is registered as the in-flight PC.
REQ-020 O_IMem_Addr SHALL hold its last issued value when O_IMem_Re=0.
REQ-021 The cycle after an issue, I_IMem_Data and the in-flight PC SHALL be written to the tail entry unless I_Flush is asserted in that cycle.
REQ-022 Fetch latency: an instruction issued in cycle N SHALL appear as O_Valid=1 in cycle N+2 if the queue was empty.
REQ-023 O_Valid = (Count>0) & state!=FLUSH; O_Instr and O_PC SHALL come from the head entry, registered storage only.
REQ-024 Pop on O_Valid & I_Ready; head pointer advances modulo DEPTH.
REQ-025 A simultaneous push and pop SHALL leave Count unchanged and advance both pointers.
REQ-026 Tail pointer wraps modulo DEPTH; Count SHALL never exceed DEPTH nor go below 0.
REQ-027 O_StallReq = I_IFetch & ~(issue condition) & ~I_Flush.
REQ-028 I_Flush SHALL clear Count, both pointers and InFlight at the next edge; I_IFetch in the flush cycle is dropped and no read is issued.
REQ-029 In the FLUSH state, O_Valid=0, O_IMem_Re=0, and any I_IFetch SHALL raise O_StallReq.
REQ-030 I_Ready with O_Valid=0 SHALL have no effect.

Reset
REQ-031 While reset=0: state=IDLE, Count=0, pointers=0, InFlight=0, O_Valid=0, O_IMem_Re=0, O_IMem_Addr=0, O_Instr=0, O_PC=0, O_StallReq=0.
REQ-032 Reset asserted mid-operation SHALL discard all entries and the in-flight read immediately; the read data returned after reset release SHALL be ignored.

Verification
REQ-033 Streaming: I_IFetch in cycles 1-4 with addresses 0x10-0x13 and I_Ready=1 -> O_IMem_Re high for cycles 1-4; O_Valid in cycles 3-6 with O_PC 0x10..0x13 in order.
REQ-034 Fill: DEPTH=4, I_Ready=0, I_IFetch held high -> exactly 4 reads issued; O_StallReq=1 from the 5th request onward; one pop releases exactly one issue in the following cycle.
REQ-035 Flush with in-flight read: issue 0x20, assert I_Flush the next cycle -> data for 0x20 is not enqueued, O_Valid=0 for 2 cycles, and the next fetch of 0x40 is the first output.
REQ-036 Wrap-around: 10 push/pop pairs at steady state, DEPTH=4 -> PCs output in issue order with no loss or duplication; Count stays at or below 1.
REQ-037 Full with simultaneous pop: Count=4, I_Ready=1, I_IFetch=1 -> no issue that cycle, Count=3, O_StallReq=1; issue occurs in the next cycle.
REQ-038 Async reset: drive reset low between clock edges with 3 entries queued -> O_Valid=0 before the next edge; after release, a first fetch of 0x00 yields O_PC=0x00.
